// File: rtl/mem_arb2.sv
// mem_arb2: two-requester round-robin arbiter in front of a single memory port.
//
// A grant latches the winner's address, write data and write enable into the
// memory-side registers and holds them for the whole BUSY phase. The transaction
// ends on mem_ack (read data captured) or on timeout (err raised, rdata zeroed),
// followed by a single RESP cycle that pulses the winner's ack.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0/1                transaction requests
//   addr0/1, wdata0/1     request address and write data
//   we0/1                 write enable (0 = read)
//   mem_en                high while a transaction is on the memory port
//   mem_sel               index of the granted requester
//   mem_addr/wdata/we     registered operands of the granted requester
//   mem_ack, mem_rdata    memory completion strobe and read data
//   ack0/1                one-cycle completion pulse per requester
//   rdata                 read data, valid while ackN is high
//   err                   timeout flag, valid while ackN is high
module mem_arb2 #(
    parameter int unsigned TMO_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        mem_en,
    output logic        mem_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    localparam logic [3:0] TMO_LAST = 4'(TMO_MAX - 1);

    state_t      r_state;
    logic        r_last;
    logic [3:0]  r_cnt;
    logic        r_mem_en;
    logic        r_mem_sel;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_we;
    logic        r_ack0;
    logic        r_ack1;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_any;
    logic        w_win;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_we;

    // Under contention the requester that did not win last time is served.
    always_comb begin
        w_any   = req0 | req1;
        w_win   = (req0 & req1) ? ~r_last : req1;
        w_addr  = w_win ? addr1  : addr0;
        w_wdata = w_win ? wdata1 : wdata0;
        w_we    = w_win ? we1    : we0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_sel   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_err  <= 1'b0;
                    if (w_any) begin
                        r_state     <= ST_BUSY;
                        r_mem_en    <= 1'b1;
                        r_mem_sel   <= w_win;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_mem_we    <= w_we;
                        r_last      <= w_win;
                        r_cnt       <= '0;
                    end
                end
                ST_BUSY: begin
                    // mem_ack is tested first so it wins over a coinciding timeout.
                    if (mem_ack) begin
                        r_state  <= ST_RESP;
                        r_mem_en <= 1'b0;
                        r_rdata  <= mem_rdata;
                        r_err    <= 1'b0;
                        r_ack0   <= ~r_mem_sel;
                        r_ack1   <= r_mem_sel;
                    end else if (r_cnt == TMO_LAST) begin
                        r_state  <= ST_RESP;
                        r_mem_en <= 1'b0;
                        r_rdata  <= '0;
                        r_err    <= 1'b1;
                        r_ack0   <= ~r_mem_sel;
                        r_ack1   <= r_mem_sel;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_err    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_sel   = r_mem_sel;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata     = r_rdata;
    assign err       = r_err;

endmodule
